app_pmem_arb: RTL

- Owns the single-port application-processor program memory and decides who drives it: the app CPU fetch port or the radio-side firmware loader port.
- Sequences the handover between the two owners, with quiesce and release phases.
- Generates the app CPU reset, including a programmable post-load release delay.
- Flags illegal or out-of-range loader traffic.
- Sits between the loader peripheral, the app CPU pmem interface and the pmem macro.

---
 rtl/app_pmem_arb_if.sv | 45 ++++
 rtl/app_pmem_arb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/app_pmem_arb_if.sv
`default_nettype none
// =============================================================================
// Module   : app_pmem_arb_if
// Purpose  : Loader, app-CPU and pmem-macro buses arbitrated by app_pmem_arb.
// Revision : 1.0 - initial release
// =============================================================================
interface app_pmem_arb_if #(
    parameter int AW = 12
);
    logic [AW-1:0] ldr_addr;
    logic [15:0]   ldr_din;
    logic          ldr_cen;
    logic [1:0]    ldr_wen;

    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_din;
    logic          cpu_cen;
    logic [1:0]    cpu_wen;
    logic [15:0]   cpu_dout;

    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic          mem_cen;
    logic [1:0]    mem_wen;
    logic [15:0]   mem_dout;

    // slave: the arbiter's view
    modport slave (
        input  ldr_addr, ldr_din, ldr_cen, ldr_wen,
        input  cpu_addr, cpu_din, cpu_cen, cpu_wen,
        output cpu_dout,
        output mem_addr, mem_din, mem_cen, mem_wen,
        input  mem_dout
    );

    // master: loader, CPU and pmem macro around the arbiter
    modport master (
        output ldr_addr, ldr_din, ldr_cen, ldr_wen,
        output cpu_addr, cpu_din, cpu_cen, cpu_wen,
        input  cpu_dout,
        input  mem_addr, mem_din, mem_cen, mem_wen,
        output mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/app_pmem_arb.sv
`default_nettype none
// =============================================================================
// Module   : app_pmem_arb
// Purpose  : App pmem ownership arbiter (CPU fetch vs. firmware loader) with
//            app CPU reset sequencing. Optional: APP_PMEM_CKSUM_EN.
// Revision : 1.0 - initial release
// =============================================================================
module app_pmem_arb #(
    parameter int AW          = 12,
    parameter int PMEM_WORDS  = 4096,
    parameter int RELEASE_DLY = 8
) (
    input  wire logic      mclk,
    input  wire logic      reset_n,
    input  wire logic      ldr_reset_n,
    app_pmem_arb_if.slave  bus,
    output logic           app_puc_n,
    output logic [1:0]     state,
    output logic [AW:0]    wr_count,
    output logic           err_drop,
    output logic           err_oob,
    output logic [15:0]    cksum
);

    localparam int              c_cnt_w = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_dly     = c_cnt_w'(RELEASE_DLY);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [AW:0]     c_words   = (AW + 1)'(PMEM_WORDS);
    localparam logic [AW:0]     c_wr_one  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_QUIESCE = 2'b01,
        ST_LOAD    = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_puc_n;
    logic               w_puc_n_nxt;
    logic [AW:0]        r_wr_count;
    logic               r_err_drop;
    logic               r_err_oob;

    logic               w_clear;
    logic               w_set_drop;
    logic               w_set_oob;
    logic               w_ldr_wr;
    logic               w_ldr_oob;
    logic [AW-1:0]      w_mem_addr;
    logic [15:0]        w_mem_din;
    logic               w_mem_cen;
    logic [1:0]         w_mem_wen;
    logic [15:0]        w_cpu_dout;

    assign w_ldr_oob = ({1'b0, bus.ldr_addr} >= c_words);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RELEASE;
            r_cnt      <= c_dly;
            r_puc_n    <= 1'b0;
            r_wr_count <= '0;
            r_err_drop <= 1'b0;
            r_err_oob  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_puc_n <= w_puc_n_nxt;
            if (w_clear) begin
                r_wr_count <= '0;
                r_err_drop <= 1'b0;
                r_err_oob  <= 1'b0;
            end else begin
                if (w_ldr_wr && (r_wr_count < c_words)) begin
                    r_wr_count <= r_wr_count + c_wr_one;
                end
                if (w_set_drop) begin
                    r_err_drop <= 1'b1;
                end
                if (w_set_oob) begin
                    r_err_oob <= 1'b1;
                end
            end
        end
    end

    // The mux follows the registered state only, so loader strobes pass straight through.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_puc_n_nxt = r_puc_n;
        w_clear     = 1'b0;
        w_set_drop  = 1'b0;
        w_set_oob   = 1'b0;
        w_ldr_wr    = 1'b0;
        w_mem_addr  = bus.cpu_addr;
        w_mem_din   = bus.cpu_din;
        w_mem_cen   = 1'b1;
        w_mem_wen   = 2'b11;
        w_cpu_dout  = 16'h0000;
        case (r_state)
            ST_RUN: begin
                w_mem_cen  = bus.cpu_cen;
                w_mem_wen  = bus.cpu_wen;
                w_cpu_dout = bus.mem_dout;
                w_set_drop = ~bus.ldr_cen;
                if (!ldr_reset_n) begin
                    w_state_nxt = ST_QUIESCE;
                    w_puc_n_nxt = 1'b0;
                end
            end
            ST_QUIESCE: begin
                w_clear     = 1'b1;
                w_state_nxt = ST_LOAD;
                w_puc_n_nxt = 1'b0;
            end
            ST_LOAD: begin
                w_mem_addr  = bus.ldr_addr;
                w_mem_din   = bus.ldr_din;
                w_puc_n_nxt = 1'b0;
                if (!bus.ldr_cen && w_ldr_oob) begin
                    w_set_oob = 1'b1;
                end else begin
                    w_mem_cen = bus.ldr_cen;
                    w_mem_wen = bus.ldr_wen;
                    w_ldr_wr  = ~bus.ldr_cen & (bus.ldr_wen != 2'b11);
                end
                if (ldr_reset_n) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = c_dly;
                end
            end
            ST_RELEASE: begin
                w_set_drop = ~bus.ldr_cen;
                if (!ldr_reset_n) begin
                    w_state_nxt = ST_QUIESCE;
                    w_puc_n_nxt = 1'b0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                    w_puc_n_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASE;
                w_cnt_nxt   = c_dly;
                w_puc_n_nxt = 1'b0;
            end
        endcase
    end

`ifdef APP_PMEM_CKSUM_EN
    logic [15:0] r_cksum;
    logic [15:0] w_ck_mask;

    assign w_ck_mask = {{8{~bus.ldr_wen[1]}}, {8{~bus.ldr_wen[0]}}};

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cksum <= 16'h0000;
        end else if (w_clear) begin
            r_cksum <= 16'h0000;
        end else if (w_ldr_wr) begin
            r_cksum <= r_cksum + (bus.ldr_din & w_ck_mask);
        end
    end

    assign cksum = r_cksum;
`else
    assign cksum = 16'h0000;
`endif

    assign bus.mem_addr = w_mem_addr;
    assign bus.mem_din  = w_mem_din;
    assign bus.mem_cen  = w_mem_cen;
    assign bus.mem_wen  = w_mem_wen;
    assign bus.cpu_dout = w_cpu_dout;
    assign app_puc_n    = r_puc_n;
    assign state        = r_state;
    assign wr_count     = r_wr_count;
    assign err_drop     = r_err_drop;
    assign err_oob      = r_err_oob;

endmodule
`default_nettype wire
